// File: rtl/l2_dma_rd_streamer_if.sv
// Bundle of the descriptor, L2 DMA read port and output stream signals of
// l2_dma_rd_streamer.
//   slave  : view of the streamer (takes descriptors, drives L2 reads and stream)
//   master : view of the environment (issues descriptors, returns data, consumes stream)
interface l2_dma_rd_streamer_if #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned LEN_W  = 11
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [ADDR_W-1:0] cmd_stride;
    logic              dma_rd_en;
    logic [ADDR_W-1:0] dma_rd_addr;
    logic [DATA_W-1:0] dma_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_stride, dma_rd_data, out_ready,
        output cmd_ready, dma_rd_en, dma_rd_addr, out_valid, out_data, out_last, busy, done
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_stride, dma_rd_data, out_ready,
        input  cmd_ready, dma_rd_en, dma_rd_addr, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/l2_dma_rd_streamer.sv
// Read-side DMA streamer: takes a burst descriptor, issues one L2 read per
// cycle under a FIFO credit limit, captures the data one cycle later into a
// small FIFO and presents it as a valid/ready stream with a last-beat flag.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : l2_dma_rd_streamer_if.slave (descriptor, L2 read port, stream,
//              busy/done status)
// Optional feature: define L2_DMA_RD_STRIDE_EN to honour cmd_stride; when
// undefined the address step is fixed at 1 and cmd_stride is ignored.
module l2_dma_rd_streamer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned LEN_W      = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    l2_dma_rd_streamer_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, rd_addr_q, rd_addr_d, stride;
    logic [LEN_W-1:0]  len_q, len_d, issued_q, issued_d, popped_q, popped_d;
    logic              rd_en_q, rd_en_d, inflight_q;
    logic              cmd_ready_q, cmd_ready_d, busy_q, busy_d, done_q, done_d;
    logic              accept;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push, pop, fifo_nonempty;
    logic [SUM_W-1:0]  credit_used;

`ifdef L2_DMA_RD_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;

    // Stride captured with the descriptor
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stride_q <= '0;
        end else if (accept) begin
            stride_q <= bus.cmd_stride;
        end
    end

    assign stride = stride_q;
`else
    logic unused_stride;

    assign stride        = ADDR_W'(1);
    assign unused_stride = ^bus.cmd_stride;
`endif

    assign fifo_nonempty = (count_q != '0);
    assign push          = inflight_q;
    assign pop           = fifo_nonempty & bus.out_ready;

    // Slots committed for the cycle after a new issue: stored beats, the beat
    // returning now, and the read already on the port. Pops are ignored, which
    // is conservative yet still sustains one beat per cycle.
    assign credit_used = SUM_W'(count_q) + SUM_W'(inflight_q) + SUM_W'(rd_en_q);

    // Next-state and registered-output decode
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_addr_d = rd_addr_q;
        len_d     = len_q;
        issued_d  = issued_q;
        popped_d  = popped_q;
        rd_en_d   = 1'b0;
        done_d    = 1'b0;
        accept    = 1'b0;

        if (pop) begin
            popped_d = popped_q + LEN_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (cmd_ready_q && bus.cmd_valid) begin
                    accept   = 1'b1;
                    addr_d   = bus.cmd_addr;
                    len_d    = bus.cmd_len;
                    issued_d = '0;
                    popped_d = '0;
                    if (bus.cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if ((issued_q < len_q) && (credit_used < SUM_W'(FIFO_DEPTH))) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_q;
                    addr_d    = addr_q + stride;
                    issued_d  = issued_q + LEN_W'(1);
                    if (issued_q == len_q - LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && (popped_q == len_q - LEN_W'(1))) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // cmd_ready stays low during the done pulse
        cmd_ready_d = (state_d == IDLE) && !done_d;
        busy_d      = (state_d != IDLE);
    end

    // State and control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rd_addr_q   <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            rd_en_q     <= 1'b0;
            inflight_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_addr_q   <= rd_addr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            popped_q    <= popped_d;
            rd_en_q     <= rd_en_d;
            inflight_q  <= rd_en_q;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage; contents are masked at the output while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.dma_rd_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_q == CNT_W'(FIFO_DEPTH))));

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.dma_rd_en   = rd_en_q;
    assign bus.dma_rd_addr = rd_addr_q;
    assign bus.out_valid   = fifo_nonempty;
    assign bus.out_data    = fifo_nonempty ? mem_q[rd_ptr_q] : '0;
    assign bus.out_last    = fifo_nonempty && (popped_q == len_q - LEN_W'(1));
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_l2_dma_rd_streamer.sv
// Testbench for l2_dma_rd_streamer: directed descriptors, an L2 memory model
// returning address-derived data, and a per-cycle burst-level reference model.
module tb_l2_dma_rd_streamer;
    localparam int unsigned DEPTH = 4;

`ifdef L2_DMA_RD_STRIDE_EN
    localparam bit STRIDE_EN = 1'b1;
`else
    localparam bit STRIDE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    l2_dma_rd_streamer_if #(.DATA_W(256), .ADDR_W(13), .LEN_W(11)) bus ();

    l2_dma_rd_streamer #(
        .FIFO_DEPTH(DEPTH), .DATA_W(256), .ADDR_W(13), .LEN_W(11)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] word(input logic [12:0] a);
        logic [255:0] w;
        for (int i = 0; i < 8; i++) begin
            w[i*32 +: 32] = {a, 3'(i), 16'hBEEF ^ 16'(a)};
        end
        return w;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // L2 memory: data for the address read in the previous cycle
    always @(posedge clk) begin
        bus.dma_rd_data <= bus.dma_rd_en ? word(bus.dma_rd_addr) : {8{32'hDEAD_BEEF}};
    end

    // Reference model state
    logic [12:0]  exp_addr_q[$];
    logic [255:0] exp_beat_q[$];
    logic [12:0]  rd_log[$];
    int  cur_len = 0, beat_idx = 0, burst_rd = 0, rd_total = 0;
    bit  active = 1'b0, done_pending = 1'b0, exp_done;
    int  acc_cyc = 0, first_rd_cyc = -1, first_valid_cyc = -1, done_cyc = -1;
    logic [12:0] ma, mstride;

    // Compare process: checks all DUT outputs against the model every cycle
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
            chk("rst_dma_rd_en", bus.dma_rd_en, 1'b0);
            chk("rst_dma_rd_addr", bus.dma_rd_addr, 13'h0);
            chk("rst_out_valid", bus.out_valid, 1'b0);
            chk("rst_out_data", bus.out_data, 256'h0);
            chk("rst_out_last", bus.out_last, 1'b0);
            chk("rst_busy", bus.busy, 1'b0);
            chk("rst_done", bus.done, 1'b0);
            exp_addr_q.delete();
            exp_beat_q.delete();
            active = 1'b0; done_pending = 1'b0;
            cur_len = 0; beat_idx = 0; burst_rd = 0;
        end else begin
            exp_done = done_pending;
            done_pending = 1'b0;
            chk("done", bus.done, exp_done);
            if (exp_done) begin
                active = 1'b0;
                done_cyc = cyc;
            end
            chk("busy", bus.busy, active);
            chk("cmd_ready", bus.cmd_ready, !active && !exp_done);

            if (bus.dma_rd_en) begin
                rd_total++;
                burst_rd++;
                rd_log.push_back(bus.dma_rd_addr);
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (exp_addr_q.size() == 0) chk("rd_spurious", 1'b1, 1'b0);
                else chk("rd_addr", bus.dma_rd_addr, exp_addr_q.pop_front());
            end
            if (active) chk("credit", 1'((burst_rd - beat_idx) <= DEPTH), 1'b1);

            if (bus.out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_beat_q.size() == 0) begin
                    chk("beat_spurious", 1'b1, 1'b0);
                end else begin
                    chk("out_data", bus.out_data, exp_beat_q[0]);
                    chk("out_last", bus.out_last, 1'(beat_idx == cur_len - 1));
                    if (bus.out_ready) begin
                        void'(exp_beat_q.pop_front());
                        beat_idx++;
                        if (beat_idx == cur_len) done_pending = 1'b1;
                    end
                end
            end

            if (bus.cmd_valid && bus.cmd_ready) begin
                acc_cyc = cyc + 1;
                first_rd_cyc = -1; first_valid_cyc = -1;
                cur_len = int'(bus.cmd_len);
                beat_idx = 0; burst_rd = 0;
                ma = bus.cmd_addr;
                mstride = STRIDE_EN ? bus.cmd_stride : 13'h1;
                for (int i = 0; i < cur_len; i++) begin
                    exp_addr_q.push_back(ma);
                    exp_beat_q.push_back(word(ma));
                    ma = ma + mstride;
                end
                if (cur_len == 0) done_pending = 1'b1;
                else active = 1'b1;
            end
        end
    end

    task automatic send(input logic [12:0] a, input logic [10:0] l, input logic [12:0] s);
        int n = 0;
        rd_log.delete();
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_len = l; bus.cmd_stride = s;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cmd_ready && n < 50);
        if (!bus.cmd_ready) chk("cmd_accept_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < budget);
        chk("done_seen", bus.done, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        int rdb;
        int n;
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_stride = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic burst: timing pinned to acceptance edge
        send(13'h0000, 11'd4, 13'h1);
        wait_done(40);
        chk("t1_first_rd", 32'(first_rd_cyc), 32'(acc_cyc + 1));
        chk("t1_first_valid", 32'(first_valid_cyc), 32'(acc_cyc + 3));
        chk("t1_done_cyc", 32'(done_cyc), 32'(acc_cyc + 7));
        chk("t1_nreads", 32'(rd_log.size()), 32'd4);
        chk("t1_addr3", rd_log[3], 13'h0003);

        // Address wrap
        send(13'h1FFE, 11'd4, 13'h1);
        wait_done(40);
        chk("t2_nreads", 32'(rd_log.size()), 32'd4);
        chk("t2_addr0", rd_log[0], 13'h1FFE);
        chk("t2_addr1", rd_log[1], 13'h1FFF);
        chk("t2_addr2", rd_log[2], 13'h0000);
        chk("t2_addr3", rd_log[3], 13'h0001);

        // Back-pressure: stalled consumer limits reads to the FIFO depth
        bus.out_ready = 1'b0;
        send(13'h0100, 11'd8, 13'h1);
        repeat (10) @(negedge clk);
        chk("t3_stall_reads_le_depth", 1'(rd_log.size() <= DEPTH), 1'b1);
        chk("t3_stall_reads_nonzero", 1'(rd_log.size() > 0), 1'b1);
        chk("t3_stall_valid", bus.out_valid, 1'b1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_done(80);
        chk("t3_nreads", 32'(rd_log.size()), 32'd8);

        // Zero-length descriptor
        rdb = rd_total;
        send(13'h0055, 11'd0, 13'h1);
        wait_done(5);
        chk("t4_no_reads", 32'(rd_total), 32'(rdb));
        chk("t4_done_cyc", 32'(done_cyc), 32'(acc_cyc));

        // Reset mid-burst, then a fresh burst
        send(13'h0200, 11'd6, 13'h1);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (rd_log.size() < 3 && n < 40);
        chk("t5_three_issued", 32'(rd_log.size()), 32'd3);
        rst = 1'b1;
        #1;
        chk("t5_rd_en_async", bus.dma_rd_en, 1'b0);
        chk("t5_out_valid_async", bus.out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(13'h0300, 11'd2, 13'h1);
        wait_done(40);
        chk("t5_nreads", 32'(rd_log.size()), 32'd2);
        chk("t5_addr1", rd_log[1], 13'h0301);

        // Stride
        send(13'h0000, 11'd3, 13'h0400);
        wait_done(40);
        chk("t6_nreads", 32'(rd_log.size()), 32'd3);
        chk("t6_addr0", rd_log[0], 13'h0000);
        chk("t6_addr1", rd_log[1], STRIDE_EN ? 13'h0400 : 13'h0001);
        chk("t6_addr2", rd_log[2], STRIDE_EN ? 13'h0800 : 13'h0002);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
